// File: rtl/cpu2core_pkg.sv
// Shared definitions for the cpu2core system-ID checker.
//   - sysid_state_t : checker sequencer states (also exported on the debug port)
//   - SYSID_ADDR_*  : word addresses inside the sysid slave
//   - SYSID_DEFAULT_*: expected contents, shared with system generation
package cpu2core_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ_ID  = 3'd1,
    ST_WAIT_ID = 3'd2,
    ST_REQ_TS  = 3'd3,
    ST_WAIT_TS = 3'd4,
    ST_DONE    = 3'd5
  } sysid_state_t;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  localparam logic [31:0] SYSID_DEFAULT_ID = 32'h0000_0000;
  localparam logic [31:0] SYSID_DEFAULT_TS = 32'd1446515335;

endpackage

// File: rtl/cpu2core_sysid_checker_if.sv
// Avalon-MM read-only link between the checker (master) and the sysid slave.
//   address       : word address (0 = system ID, 1 = build timestamp)
//   read          : read request
//   waitrequest   : slave stall
//   readdatavalid : read data valid
//   readdata      : 32-bit read data
//
// Handshake: the master raises read with a stable address and holds both
// unchanged while waitrequest=1. The request is accepted in the cycle where
// read=1 and waitrequest=0. Exactly one readdatavalid pulse returns the data,
// either in the accept cycle itself or in a later cycle; the master keeps at
// most one read outstanding.
interface cpu2core_sysid_checker_if;
  logic        address;
  logic        read;
  logic        waitrequest;
  logic        readdatavalid;
  logic [31:0] readdata;

  modport master (
    output address,
    output read,
    input  waitrequest,
    input  readdatavalid,
    input  readdata
  );

  modport slave (
    input  address,
    input  read,
    output waitrequest,
    output readdatavalid,
    output readdata
  );
endinterface

// File: rtl/cpu2core_sysid_checker.sv
// System-ID checker: reads word 0 (ID) and word 1 (build timestamp) from the
// sysid slave and compares them against build-time constants, giving a
// go/no-go indication before the Nios II cores are released.
// Ports:
//   clock, reset : clock, asynchronous active-high reset
//   start        : pulse, starts a check sequence (ignored while busy)
//   avm          : Avalon-MM read master towards the sysid slave
//   busy         : sequence in progress
//   done         : sticky, sequence finished (cleared by the next accepted start)
//   id_ok, ts_ok : captured words matched the expected values (valid with done)
//   timeout      : a read did not complete within TIMEOUT_CYC cycles
//   id_value     : captured ID word
//   ts_value     : captured timestamp word
//   dbg_state    : current sequencer state
module cpu2core_sysid_checker
  import cpu2core_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID = SYSID_DEFAULT_ID,
  parameter logic [31:0] EXPECTED_TS = SYSID_DEFAULT_TS,
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter bit          AUTO_START  = 1'b1
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            start,
  cpu2core_sysid_checker_if.master        avm,
  output logic                            busy,
  output logic                            done,
  output logic                            id_ok,
  output logic                            ts_ok,
  output logic                            timeout,
  output logic [31:0]                     id_value,
  output logic [31:0]                     ts_value,
  output sysid_state_t                    dbg_state
);

  // The timer holds the number of cycles already spent in the current read,
  // so the read expires in the cycle where it equals TIMEOUT_CYC-1.
  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYC - 1);

  sysid_state_t state_q, state_d;
  logic [15:0]  timer_q, timer_d;
  logic         auto_q;
  logic         cmp_q, cmp_d;
  logic         done_q, done_d;
  logic         id_ok_q, id_ok_d;
  logic         ts_ok_q, ts_ok_d;
  logic         timeout_q, timeout_d;
  logic [31:0]  id_value_q, id_value_d;
  logic [31:0]  ts_value_q, ts_value_d;

  logic in_req, in_wait, accept, capture, expired;

  assign in_req  = (state_q == ST_REQ_ID)  || (state_q == ST_REQ_TS);
  assign in_wait = (state_q == ST_WAIT_ID) || (state_q == ST_WAIT_TS);
  assign accept  = in_req && !avm.waitrequest;
  // Data counts only in a WAIT state or in the accept cycle; any other pulse is stray.
  assign capture = (accept || in_wait) && avm.readdatavalid;
  // Capture wins over expiry when data arrives in the last allowed cycle.
  assign expired = (in_req || in_wait) && !capture && (timer_q == TIMER_LAST);

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    cmp_d      = 1'b0;
    done_d     = done_q;
    id_ok_d    = id_ok_q;
    ts_ok_d    = ts_ok_q;
    timeout_d  = timeout_q;
    id_value_d = id_value_q;
    ts_value_d = ts_value_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start || auto_q) begin
          state_d   = ST_REQ_ID;
          timer_d   = '0;
          done_d    = 1'b0;
          id_ok_d   = 1'b0;
          ts_ok_d   = 1'b0;
          timeout_d = 1'b0;
        end
      end

      ST_REQ_ID, ST_WAIT_ID: begin
        timer_d = timer_q + 16'd1;
        if (capture) begin
          id_value_d = avm.readdata;
          state_d    = ST_REQ_TS;
          timer_d    = '0;
        end else if (expired) begin
          state_d   = ST_DONE;
          done_d    = 1'b1;
          timeout_d = 1'b1;
        end else if (accept) begin
          state_d = ST_WAIT_ID;
        end
      end

      ST_REQ_TS, ST_WAIT_TS: begin
        timer_d = timer_q + 16'd1;
        if (capture) begin
          ts_value_d = avm.readdata;
          state_d    = ST_DONE;
          cmp_d      = 1'b1;
        end else if (expired) begin
          state_d   = ST_DONE;
          done_d    = 1'b1;
          timeout_d = 1'b1;
        end else if (accept) begin
          state_d = ST_WAIT_TS;
        end
      end

      ST_DONE: begin
        // First DONE cycle after a full capture: compare the registered words
        // and raise done together with the result.
        if (cmp_q) begin
          done_d  = 1'b1;
          id_ok_d = (id_value_q == EXPECTED_ID);
          ts_ok_d = (ts_value_q == EXPECTED_TS);
        end else if (start) begin
          state_d   = ST_REQ_ID;
          timer_d   = '0;
          done_d    = 1'b0;
          id_ok_d   = 1'b0;
          ts_ok_d   = 1'b0;
          timeout_d = 1'b0;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      auto_q     <= AUTO_START;
      cmp_q      <= 1'b0;
      done_q     <= 1'b0;
      id_ok_q    <= 1'b0;
      ts_ok_q    <= 1'b0;
      timeout_q  <= 1'b0;
      id_value_q <= '0;
      ts_value_q <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      auto_q     <= 1'b0;
      cmp_q      <= cmp_d;
      done_q     <= done_d;
      id_ok_q    <= id_ok_d;
      ts_ok_q    <= ts_ok_d;
      timeout_q  <= timeout_d;
      id_value_q <= id_value_d;
      ts_value_q <= ts_value_d;
    end
  end

  // Request lines decode straight from the state register, so the
  // asynchronous reset drops avm.read immediately.
  assign avm.read    = in_req;
  assign avm.address = (state_q == ST_REQ_TS) ? SYSID_ADDR_TS : SYSID_ADDR_ID;

  // Busy also covers the compare cycle so a start cannot slip in before done.
  assign busy      = in_req || in_wait || cmp_q;
  assign done      = done_q;
  assign id_ok     = id_ok_q;
  assign ts_ok     = ts_ok_q;
  assign timeout   = timeout_q;
  assign id_value  = id_value_q;
  assign ts_value  = ts_value_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_cpu2core_sysid_checker.sv
module tb_cpu2core_sysid_checker;

  localparam logic [31:0] EXP_ID = 32'h0000_0000;
  localparam logic [31:0] EXP_TS = 32'd1446515335;
  localparam int          TO     = 8;
  localparam int          NEVER  = -1;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  always #5 clock = ~clock;

  logic        busy, done, id_ok, ts_ok, timeout;
  logic [31:0] id_value, ts_value;
  cpu2core_pkg::sysid_state_t dbg_state;

  cpu2core_sysid_checker_if avm_if ();

  cpu2core_sysid_checker #(
    .EXPECTED_ID (EXP_ID),
    .EXPECTED_TS (EXP_TS),
    .TIMEOUT_CYC (TO),
    .AUTO_START  (1'b1)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .avm       (avm_if),
    .busy      (busy),
    .done      (done),
    .id_ok     (id_ok),
    .ts_ok     (ts_ok),
    .timeout   (timeout),
    .id_value  (id_value),
    .ts_value  (ts_value),
    .dbg_state (dbg_state)
  );

  // ---------------- check helpers ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- read plan (per sequence) ----------------
  // Per read r: pw = stall cycles, pl = data latency after accept (0 = same
  // cycle, NEVER = no data), pd = returned word.
  int          pw [2];
  int          pl [2];
  logic [31:0] pd [2];
  int          kick_cnt    = 0;
  logic        force_stray = 1'b0;

  task automatic set_plan(input int w0, input int l0, input logic [31:0] d0,
                          input int w1, input int l1, input logic [31:0] d1);
    pw[0] = w0; pl[0] = l0; pd[0] = d0;
    pw[1] = w1; pl[1] = l1; pd[1] = d1;
  endtask

  // ---------------- behavioural model ----------------
  // Timeline of busy cycles: bit1 = read expected, bit0 = expected address.
  logic [1:0]  exp_q[$];
  int          exp_len  = 0;
  logic        cur_busy = 1'b0;
  logic        res_pend = 1'b0;
  logic        res_to, res_id_ok, res_ts_ok;
  logic [31:0] res_idv, res_tsv;
  logic        st_done = 1'b0, st_id_ok = 1'b0, st_ts_ok = 1'b0, st_to = 1'b0;
  logic [31:0] st_idv = '0, st_tsv = '0;

  // A read lasts stall+1 request cycles plus the data latency; it times out
  // when that exceeds TO cycles. A full pass adds one compare cycle.
  task automatic load_model();
    int tr;
    exp_q.delete();
    res_to  = 1'b0;
    res_idv = st_idv;
    res_tsv = st_tsv;
    for (int r = 0; r < 2; r++) begin
      tr = (pl[r] < 0) ? 1000 : pw[r] + 1 + pl[r];
      for (int k = 0; k < tr && k < TO; k++) exp_q.push_back({k <= pw[r], r == 1});
      if (tr > TO) begin
        res_to = 1'b1;
        break;
      end
      if (r == 0) res_idv = pd[0];
      else        res_tsv = pd[1];
    end
    if (!res_to) exp_q.push_back(2'b00);
    res_id_ok = !res_to && (res_idv == EXP_ID);
    res_ts_ok = !res_to && (res_tsv == EXP_TS);
    exp_len   = exp_q.size();
    res_pend  = 1'b1;
  endtask

  // ---------------- compare process ----------------
  initial begin
    logic [1:0] e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cur_busy = 1'b1;
        check1("busy_active", busy, 1'b1);
        check1("done_active", done, 1'b0);
        check1("read_active", avm_if.read, e[1]);
        if (e[1]) check1("address_active", avm_if.address, e[0]);
        check1("timeout_active", timeout, 1'b0);
        check1("id_ok_active", id_ok, 1'b0);
        check1("ts_ok_active", ts_ok, 1'b0);
        if (exp_q.size() == 0 && res_pend) begin
          st_done  = 1'b1;
          st_to    = res_to;
          st_id_ok = res_id_ok;
          st_ts_ok = res_ts_ok;
          st_idv   = res_idv;
          st_tsv   = res_tsv;
          res_pend = 1'b0;
        end
      end else begin
        cur_busy = 1'b0;
        check1("busy_steady", busy, 1'b0);
        check1("read_steady", avm_if.read, 1'b0);
        check1("done_steady", done, st_done);
        check1("id_ok_steady", id_ok, st_id_ok);
        check1("ts_ok_steady", ts_ok, st_ts_ok);
        check1("timeout_steady", timeout, st_to);
        check("id_value_steady", id_value, st_idv);
        check("ts_value_steady", ts_value, st_tsv);
      end
    end
  end

  // ---------------- slave driver ----------------
  int          s_kick = 0, s_idx = 0, s_stall = 0, s_pend = 0;
  logic        s_silent = 1'b0;
  logic [31:0] s_data = '0;

  initial begin
    avm_if.waitrequest   = 1'b0;
    avm_if.readdatavalid = 1'b0;
    avm_if.readdata      = '0;
    forever begin
      @(negedge clock);
      avm_if.readdatavalid = 1'b0;
      avm_if.readdata      = $urandom;
      avm_if.waitrequest   = 1'($urandom_range(0, 1));
      if (reset) begin
        s_pend   = 0;
        s_silent = 1'b0;
      end else begin
        if (s_kick != kick_cnt) begin
          s_kick   = kick_cnt;
          s_idx    = 0;
          s_stall  = 0;
          s_silent = 1'b0;
        end
        if (s_pend > 0) begin
          s_pend--;
          if (s_pend == 0) begin
            avm_if.readdatavalid = 1'b1;
            avm_if.readdata      = s_data;
          end
        end else if (avm_if.read) begin
          if (s_idx < 2 && s_stall < pw[s_idx]) begin
            avm_if.waitrequest   = 1'b1;
            avm_if.readdatavalid = ($urandom_range(0, 2) == 0);
            s_stall++;
          end else begin
            avm_if.waitrequest = 1'b0;
            if (s_idx < 2) begin
              if (pl[s_idx] == 0) begin
                avm_if.readdatavalid = 1'b1;
                avm_if.readdata      = pd[s_idx];
              end else if (pl[s_idx] < 0) begin
                s_silent = 1'b1;
              end else begin
                s_pend = pl[s_idx];
                s_data = pd[s_idx];
              end
              s_idx++;
              s_stall = 0;
            end
          end
        end else if (!s_silent && (force_stray || $urandom_range(0, 2) == 0)) begin
          avm_if.readdatavalid = 1'b1;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_done(input bit poke, output int lat);
    lat = -1;
    for (int j = 0; j < 200; j++) begin
      @(posedge clock);
      #2;
      force_stray = 1'b0;
      if (done && !busy) begin
        lat = j;
        break;
      end
      @(negedge clock);
      start = poke && cur_busy && ($urandom_range(0, 3) == 0);
    end
    start = 1'b0;
    check1("done_reached", lat >= 0, 1'b1);
    for (int k = 0; k < 20 && s_pend != 0; k++) @(negedge clock);
  endtask

  task automatic run_seq(input bit poke, output int lat);
    @(negedge clock);
    start = 1'b1;
    if (!cur_busy) begin
      kick_cnt++;
      load_model();
    end
    wait_done(poke, lat);
    check("latency_vs_model", lat, exp_len);
  endtask

  task automatic assert_reset();
    reset    = 1'b1;
    exp_q.delete();
    res_pend = 1'b0;
    cur_busy = 1'b0;
    st_done  = 1'b0;
    st_id_ok = 1'b0;
    st_ts_ok = 1'b0;
    st_to    = 1'b0;
    st_idv   = '0;
    st_tsv   = '0;
  endtask

  // Release away from the edge; the next edge is the auto-start edge, and a
  // stray readdatavalid is forced into the idle cycle before it.
  task automatic release_reset(output int lat);
    @(posedge clock);
    #3;
    reset       = 1'b0;
    force_stray = 1'b1;
    kick_cnt++;
    load_model();
    wait_done(1'b0, lat);
    check("latency_vs_model_auto", lat, exp_len);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- main stimulus ----------------
  initial begin
    int lat;
    #1 assert_reset();
    repeat (3) @(posedge clock);
    #2;
    check1("reset_busy", busy, 1'b0);
    check1("reset_done", done, 1'b0);
    check1("reset_read", avm_if.read, 1'b0);
    check1("reset_address", avm_if.address, 1'b0);
    check("reset_id_value", id_value, 32'h0);

    // 1: zero-wait slave, auto start after reset release
    set_plan(0, 1, EXP_ID, 0, 1, EXP_TS);
    release_reset(lat);
    check("t1_latency", lat, 5);
    check1("t1_id_ok", id_ok, 1'b1);
    check1("t1_ts_ok", ts_ok, 1'b1);
    check1("t1_timeout", timeout, 1'b0);
    check("t1_ts_value", ts_value, 32'd1446515335);

    // 2: wrong ID
    set_plan(0, 1, 32'h0000_0001, 0, 1, EXP_TS);
    run_seq(1'b0, lat);
    check1("t2_id_ok", id_ok, 1'b0);
    check1("t2_ts_ok", ts_ok, 1'b1);
    check("t2_id_value", id_value, 32'h1);

    // 3: three stall cycles on each read
    set_plan(3, 1, EXP_ID, 3, 1, EXP_TS);
    run_seq(1'b0, lat);
    check("t3_latency", lat, 11);
    check1("t3_id_ok", id_ok, 1'b1);
    check1("t3_ts_ok", ts_ok, 1'b1);

    // 4: ID read never returns data
    set_plan(0, NEVER, 32'h1234_5678, 0, 1, EXP_TS);
    run_seq(1'b0, lat);
    check("t4_latency", lat, 8);
    check1("t4_timeout", timeout, 1'b1);
    check1("t4_id_ok", id_ok, 1'b0);
    check1("t4_ts_ok", ts_ok, 1'b0);
    check("t4_ts_value_kept", ts_value, 32'd1446515335);

    // 5: reset while waiting for TS data
    set_plan(0, 1, EXP_ID, 0, 3, EXP_TS);
    @(negedge clock);
    start = 1'b1;
    kick_cnt++;
    load_model();
    @(posedge clock);
    #2 start = 1'b0;
    repeat (3) @(posedge clock);
    #3;
    check1("t5_in_wait_ts", dbg_state == cpu2core_pkg::ST_WAIT_TS, 1'b1);
    assert_reset();
    #1;
    check1("t5_read_dropped", avm_if.read, 1'b0);
    check1("t5_busy", busy, 1'b0);
    check("t5_ts_value", ts_value, 32'h0);
    check1("t5_state_idle", dbg_state == cpu2core_pkg::ST_IDLE, 1'b1);
    repeat (2) @(negedge clock);
    set_plan(1, 2, EXP_ID, 0, 0, EXP_TS);
    release_reset(lat);
    check1("t5_rerun_id_ok", id_ok, 1'b1);
    check1("t5_rerun_ts_ok", ts_ok, 1'b1);

    // 6: start pulses while busy are ignored; start in DONE re-runs
    set_plan(0, 1, EXP_ID, 0, 1, EXP_TS);
    run_seq(1'b1, lat);
    check("t6_latency", lat, 5);
    set_plan(2, 0, EXP_ID, 1, 2, EXP_TS);
    run_seq(1'b1, lat);
    check1("t6_second_id_ok", id_ok, 1'b1);
    check1("t6_second_ts_ok", ts_ok, 1'b1);

    // randomized sequences
    for (int n = 0; n < 40; n++) begin
      for (int r = 0; r < 2; r++) begin
        pw[r] = ($urandom_range(0, 7) == 0) ? $urandom_range(5, 9) : $urandom_range(0, 3);
        pl[r] = ($urandom_range(0, 7) == 0) ? NEVER : $urandom_range(0, 3);
      end
      pd[0] = ($urandom_range(0, 2) != 0) ? EXP_ID : $urandom;
      pd[1] = ($urandom_range(0, 2) != 0) ? EXP_TS : $urandom;
      run_seq(1'b1, lat);
      repeat ($urandom_range(0, 3)) @(negedge clock);
    end

    repeat (2) @(posedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
